mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Bridges the processor's 32-bit fetch/load/store requests to the byte-wide system_ram port (8-bit data, 16-bit byte address).
- Serialises each access into 1, 2 or 4 byte transactions, little-endian.
- Reads: assembles the bytes and sign/zero-extends them. Writes: scatters the bytes.
- Sits between the processor FSM (FETCH/EXECUTE/WRITEBACK) and system_ram. Flags misaligned and out-of-range requests as exceptions.

Parameters:
- RAM_LATENCY, 2, cycles from ram_rden/ram_addr asserted to valid ram_q (range 1..4).
- ADDR_WIDTH, 16, system_ram byte-address width; any address with bits [31:ADDR_WIDTH] nonzero is out of range.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and able to accept
- req_we  input  1  1=store, 0=load/fetch
- req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  input  1  zero-extend load result (LBU/LHU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low bytes used per size
- done  output  1  one-cycle pulse: access complete
- err  output  1  one-cycle pulse coincident with done: request rejected
- rdata  output  32  extended load result, held until next accepted load
- ram_addr  output  ADDR_WIDTH  system_ram address
- ram_rden  output  1  system_ram read enable
- ram_wren  output  1  system_ram write enable
- ram_byte_en  output  4  driven 4'b0001 whenever rden/wren is asserted, else 0
- ram_data  output  8  byte to write
- ram_q  input  8  byte read from system_ram

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - State IDLE.
  - done, err, ram_rden, ram_wren, ram_byte_en = 0.
  - rdata = 0, ram_addr = 0, ram_data = 0.
  - Byte counter = 0.
- req_ready = (state==IDLE) && !rst, combinational.
- Accept: req_valid && req_ready at a rising edge. The unit latches addr, size, we, unsigned and wdata at that edge. Inputs are ignored while busy.
- Validation at accept. Any of the following is an error:
  - size==3
  - size==1 with addr[0]!=0
  - size==2 with addr[1:0]!=0
  - addr[31:ADDR_WIDTH]!=0
- Error response:
  - Go to RESP with err set; done=err=1 in the cycle after accept.
  - No RAM enable is asserted.
  - rdata is unchanged.
- States: IDLE -> ISSUE -> (read: WAIT) -> ... -> RESP -> IDLE.
- N = 1/2/4 bytes for size 0/1/2. Byte counter i runs 0..N-1.
- ISSUE (one cycle):
  - ram_addr = base+i (base low ADDR_WIDTH bits; no carry beyond, because alignment guarantees no wrap).
  - Read: ram_rden=1, ram_byte_en=0001, then go to WAIT.
  - Write: ram_wren=1, ram_byte_en=0001, ram_data=wdata[8i+7:8i]. Then go to ISSUE(i+1), or RESP after the last byte.
- WAIT:
  - Lasts RAM_LATENCY cycles, counted by a wait counter; enables are deasserted.
  - On the final WAIT cycle, ram_q is captured into assembly byte lane i.
  - Then go to ISSUE(i+1), or RESP after the last byte.
- RESP (one cycle):
  - done=1.
  - For a load, rdata is updated at entry to RESP, i.e. it is valid in the same cycle as done:
    - byte: signed = {{24{b0[7]}},b0}; unsigned = {24'b0,b0}
    - half: signed = {{16{b1[7]}},b1,b0}; unsigned = zero-extended
    - word: {b3,b2,b1,b0}
  - Next state IDLE. req_ready returns the following cycle, so back-to-back requests have a one-cycle gap.
- Latency, with accept at cycle 0:
  - Load done at cycle N*(1+RAM_LATENCY)+1. Word with L=2 gives cycle 13.
  - Store done at cycle N+1.
  - Error done at cycle 1.
- Reset mid-operation: on the next edge the unit is in IDLE with all enables 0 and done/err 0. The partial store is abandoned and bytes already written remain. rdata = 0.
- req_valid held during RESP is not accepted until IDLE.

Test Plan:
- Preload RAM 0x0010..0x0013 = 0x78,0x56,0x34,0x12. Word load addr 0x10, L=2 -> rdata=0x12345678, done exactly 13 cycles after accept, err=0, four rden pulses at addresses 0x10..0x13.
- Byte load 0x13 with RAM[0x13]=0x80 -> signed rdata=0xFFFFFF80; req_unsigned=1 -> 0x00000080. Half load 0x12 with bytes 0x34,0xF2 -> 0xFFFFF234 signed, 0x0000F234 unsigned.
- Word store 0xDEADBEEF to 0x20 -> wren on 4 consecutive cycles, ram_data EF,BE,AD,DE, done at cycle 5. A subsequent word load returns 0xDEADBEEF.
- Misaligned word 0x22, half 0x21, size=3, and addr 0x00010000 -> each gives done=err=1 at cycle 1, no rden/wren ever asserted, rdata unchanged.
- Assert rst during the third byte of a word store to 0x30 (first two bytes 0x11,0x22 of 0x44332211 already written) -> next cycle idle, req_ready=1, RAM[0x30..0x31] = 11,22 with upper bytes untouched. rst held high -> req_ready=0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Processor-side request/response and byte-wide system_ram signals of mem_access_unit.
// The unit connects through the slave modport; the environment through master.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_rden;
  logic                  ram_wren;
  logic [3:0]            ram_byte_en;
  logic [7:0]            ram_data;
  logic [7:0]            ram_q;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_q,
    output req_ready, done, err, rdata, ram_addr, ram_rden, ram_wren, ram_byte_en, ram_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_q,
    input  req_ready, done, err, rdata, ram_addr, ram_rden, ram_wren, ram_byte_en, ram_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Serialises 32-bit load/store requests into little-endian byte transactions on system_ram,
// with sign/zero extension of loads and rejection of misaligned or out-of-range requests.
module mem_access_unit #(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [2:0] WaitLast = 3'(RAM_LATENCY - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic                  err_q, err_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            idx_q, idx_d;
  logic [2:0]            wait_q, wait_d;

  logic       req_bad;
  logic [1:0] last_idx;
  logic       rden, wren;

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] r;
    unique case (sz)
      2'd0:    r = uns ? {24'h0, a[7:0]} : {{24{a[7]}}, a[7:0]};
      2'd1:    r = uns ? {16'h0, a[15:0]} : {{16{a[15]}}, a[15:0]};
      default: r = a;
    endcase
    return r;
  endfunction

  always_comb begin
    req_bad = (bus.req_size == 2'd3)
           || ((bus.req_size == 2'd1) && bus.req_addr[0])
           || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00))
           || ((bus.req_addr >> ADDR_WIDTH) != 32'd0);
  end

  always_comb begin
    unique case (size_q)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    wait_d  = wait_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr[ADDR_WIDTH-1:0];
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          err_d   = req_bad;
          idx_d   = 2'd0;
          asm_d   = 32'h0;
          state_d = req_bad ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          if (idx_q == last_idx) begin
            state_d = StResp;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          wait_d  = 3'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          asm_d[{idx_q, 3'b000} +: 8] = bus.ram_q;
          if (idx_q == last_idx) begin
            // rdata must be valid in the same cycle done is raised
            rdata_d = extend(asm_d, size_q, uns_q);
            state_d = StResp;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StIssue;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
      idx_q   <= 2'd0;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  // Enables drop as soon as rst rises so an interrupted store writes no further bytes
  assign rden = (state_q == StIssue) && !we_q && !rst;
  assign wren = (state_q == StIssue) && we_q && !rst;

  assign bus.req_ready   = (state_q == StIdle) && !rst;
  assign bus.ram_rden    = rden;
  assign bus.ram_wren    = wren;
  assign bus.ram_byte_en = (rden || wren) ? 4'b0001 : 4'b0000;
  assign bus.ram_addr    = addr_q + {{(ADDR_WIDTH-2){1'b0}}, idx_q};
  assign bus.ram_data    = wren ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign bus.done        = (state_q == StResp);
  assign bus.err         = (state_q == StResp) && err_q;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a two-cycle-latency byte RAM model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(16)) bus ();

  mem_access_unit #(
    .RAM_LATENCY(2),
    .ADDR_WIDTH (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM model: address sampled with rden, data valid two cycles later
  logic [7:0]  mem [0:65535];
  logic [7:0]  q0, q1;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
    q0 <= mem[bus.ram_addr];
    q1 <= q0;
  end
  assign bus.ram_q = q1;

  int vec_cnt = 0;
  int miss_cnt = 0;

  int          n_rd, n_wr;
  logic [15:0] rd_addr [8];
  logic [15:0] wr_addr [8];
  logic [7:0]  wr_data [8];
  int          wr_cyc  [8];
  int          bad_en;

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issues one request and watches the bus until done (bounded); returns at done's negedge
  task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int done_cyc, output logic err_seen);
    n_rd = 0; n_wr = 0; bad_en = 0;
    done_cyc = -1; err_seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if ((bus.ram_rden || bus.ram_wren) && bus.ram_byte_en != 4'b0001) bad_en++;
      if (bus.ram_rden) begin
        if (n_rd < 8) rd_addr[n_rd] = bus.ram_addr;
        n_rd++;
      end
      if (bus.ram_wren) begin
        if (n_wr < 8) begin
          wr_addr[n_wr] = bus.ram_addr; wr_data[n_wr] = bus.ram_data; wr_cyc[n_wr] = k;
        end
        n_wr++;
      end
      if (bus.done) begin
        done_cyc = k; err_seen = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (bus.req_ready !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_ready_in_rst: got %b want 0", bus.req_ready);
    end
    vec_cnt++;
    if ({bus.done, bus.err, bus.ram_rden, bus.ram_wren, bus.ram_byte_en} !== 8'h00) begin
      miss_cnt++;
      $display("FAIL reset_ctrl: got %b want 0",
               {bus.done, bus.err, bus.ram_rden, bus.ram_wren, bus.ram_byte_en});
    end
    vec_cnt++;
    if ({bus.rdata, bus.ram_addr, bus.ram_data} !== 56'h0) begin
      miss_cnt++;
      $display("FAIL reset_data: got %h want 0", {bus.rdata, bus.ram_addr, bus.ram_data});
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 1'b1) begin
      miss_cnt++; $display("FAIL reset_ready_after: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_word_load;
    int dc; logic e;
    poke(16'h0010, 8'h78); poke(16'h0011, 8'h56); poke(16'h0012, 8'h34); poke(16'h0013, 8'h12);
    do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, dc, e);
    vec_cnt++;
    if (bus.rdata !== 32'h12345678) begin
      miss_cnt++; $display("FAIL wload_data: got %h want 12345678", bus.rdata);
    end
    vec_cnt++;
    if (dc !== 13 || e !== 1'b0) begin
      miss_cnt++; $display("FAIL wload_timing: got cyc %0d err %b want 13 0", dc, e);
    end
    vec_cnt++;
    if (n_rd !== 4 || n_wr !== 0 || bad_en !== 0) begin
      miss_cnt++;
      $display("FAIL wload_pulses: got rd %0d wr %0d bad_en %0d want 4 0 0", n_rd, n_wr, bad_en);
    end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rd_addr[i] !== 16'h0010 + 16'(i)) begin
        miss_cnt++; $display("FAIL wload_addr%0d: got %h want %h", i, rd_addr[i], 16'h10 + i);
      end
    end
  endtask

  task automatic test_byte_half_load;
    int dc; logic e;
    poke(16'h0013, 8'h80);
    do_access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, dc, e);
    vec_cnt++;
    if (bus.rdata !== 32'hFFFFFF80 || dc !== 4) begin
      miss_cnt++; $display("FAIL lb: got %h cyc %0d want ffffff80 4", bus.rdata, dc);
    end
    do_access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, dc, e);
    vec_cnt++;
    if (bus.rdata !== 32'h00000080) begin
      miss_cnt++; $display("FAIL lbu: got %h want 00000080", bus.rdata);
    end
    poke(16'h0012, 8'h34); poke(16'h0013, 8'hF2);
    do_access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, dc, e);
    vec_cnt++;
    if (bus.rdata !== 32'hFFFFF234 || dc !== 7) begin
      miss_cnt++; $display("FAIL lh: got %h cyc %0d want fffff234 7", bus.rdata, dc);
    end
    do_access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, dc, e);
    vec_cnt++;
    if (bus.rdata !== 32'h0000F234) begin
      miss_cnt++; $display("FAIL lhu: got %h want 0000f234", bus.rdata);
    end
  endtask

  task automatic test_word_store;
    int dc; logic e;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    do_access(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, dc, e);
    vec_cnt++;
    if (dc !== 5 || e !== 1'b0 || n_wr !== 4 || n_rd !== 0) begin
      miss_cnt++;
      $display("FAIL sw_timing: got cyc %0d err %b wr %0d rd %0d want 5 0 4 0", dc, e, n_wr, n_rd);
    end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (wr_data[i] !== exp_b[i] || wr_addr[i] !== 16'h0020 + 16'(i) || wr_cyc[i] !== i + 1)
      begin
        miss_cnt++;
        $display("FAIL sw_byte%0d: got %h@%h cyc %0d want %h@%h cyc %0d", i, wr_data[i],
                 wr_addr[i], wr_cyc[i], exp_b[i], 16'h20 + i, i + 1);
      end
    end
    do_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, dc, e);
    vec_cnt++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      miss_cnt++; $display("FAIL sw_readback: got %h want deadbeef", bus.rdata);
    end
  endtask

  task automatic test_errors;
    int dc; logic e;
    logic        we_t   [4];
    logic [1:0]  sz_t   [4];
    logic [31:0] addr_t [4];
    we_t[0] = 1'b0; sz_t[0] = 2'd2; addr_t[0] = 32'h00000022;
    we_t[1] = 1'b1; sz_t[1] = 2'd1; addr_t[1] = 32'h00000021;
    we_t[2] = 1'b0; sz_t[2] = 2'd3; addr_t[2] = 32'h00000040;
    we_t[3] = 1'b0; sz_t[3] = 2'd0; addr_t[3] = 32'h00010000;
    for (int i = 0; i < 4; i++) begin
      do_access(we_t[i], sz_t[i], 1'b0, addr_t[i], 32'h55667788, dc, e);
      vec_cnt++;
      if (dc !== 1 || e !== 1'b1 || n_rd !== 0 || n_wr !== 0) begin
        miss_cnt++;
        $display("FAIL err%0d: got cyc %0d err %b rd %0d wr %0d want 1 1 0 0",
                 i, dc, e, n_rd, n_wr);
      end
      vec_cnt++;
      if (bus.rdata !== 32'hDEADBEEF) begin
        miss_cnt++; $display("FAIL err%0d_rdata: got %h want deadbeef", i, bus.rdata);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dc; logic e;
    do_access(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, dc, e);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_addr = 32'h11;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 1'b0 || bus.rdata !== 32'h00000078) begin
      miss_cnt++;
      $display("FAIL b2b_resp: got ready %b rdata %h want 0 00000078", bus.req_ready, bus.rdata);
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.req_ready !== 1'b1 || bus.ram_rden !== 1'b0) begin
      miss_cnt++;
      $display("FAIL b2b_gap: got ready %b rden %b want 1 0", bus.req_ready, bus.ram_rden);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (bus.ram_rden !== 1'b1 || bus.ram_addr !== 16'h0011) begin
      miss_cnt++;
      $display("FAIL b2b_next: got rden %b addr %h want 1 0011", bus.ram_rden, bus.ram_addr);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_store;
    poke(16'h0030, 8'hAA); poke(16'h0031, 8'hBB); poke(16'h0032, 8'hCC); poke(16'h0033, 8'hDD);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h30; bus.req_wdata = 32'h44332211;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (bus.ram_wren !== 1'b1 || bus.ram_addr !== 16'h0032 || bus.ram_data !== 8'h33) begin
      miss_cnt++;
      $display("FAIL rst_mid_third: got wren %b addr %h data %h want 1 0032 33",
               bus.ram_wren, bus.ram_addr, bus.ram_data);
    end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (bus.req_ready !== 1'b0 || bus.ram_wren !== 1'b0 || bus.done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rst_mid_held: got ready %b wren %b done %b want 0 0 0",
               bus.req_ready, bus.ram_wren, bus.done);
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 1'b1 || bus.err !== 1'b0 || bus.rdata !== 32'h0) begin
      miss_cnt++;
      $display("FAIL rst_mid_idle: got ready %b err %b rdata %h want 1 0 0",
               bus.req_ready, bus.err, bus.rdata);
    end
    @(negedge clk);
    vec_cnt++;
    if ({mem[16'h30], mem[16'h31], mem[16'h32], mem[16'h33]} !== 32'h1122CCDD) begin
      miss_cnt++;
      $display("FAIL rst_mid_ram: got %h want 1122ccdd",
               {mem[16'h30], mem[16'h31], mem[16'h32], mem[16'h33]});
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_word_load();
    test_byte_half_load();
    test_word_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
